// File: rtl/clk_rst_seq_pkg.sv
// Shared definitions for the clock-tree reset sequencer.
// Holds the state encoding, which is also what state_o reports, and a small
// helper for sizing the shared cycle counter.
package clk_rst_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET    = 3'd0,
        ST_WAIT_DCM = 3'd1,
        ST_WAIT_PLL = 3'd2,
        ST_STABLE   = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_RUN      = 3'd5,
        ST_FAULT    = 3'd6
    } state_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_rst_seq_lock_sync.sv
// lock_sync: two-flop synchronizer for asynchronous lock flags.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears both stages to 0
//   d_i  - asynchronous input flags (WIDTH bits)
//   q_o  - synchronized flags, two clk cycles of latency
module lock_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: lock supervisor and reset sequencer for the clock tree.
// Holds DCM/PLL in reset, waits for their locks, requires a stable-lock
// window, then releases domain resets one at a time. Lock loss retries the
// bring-up; too many consecutive failures latch FAULT until restart_i.
// Ports:
//   sys_clk_i     - free-running board clock (only clock)
//   sys_rst_i     - asynchronous active-high reset
//   dcm_locked_i  - DCM lock flags (async)
//   pll_locked_i  - PLL lock flag (async)
//   restart_i     - one-cycle synchronous restart request
//   dcm_rst_o     - reset to both DCMs
//   pll_rst_o     - reset to PLL
//   domain_rst_o  - per-domain resets, bit 0 released first
//   ready_o       - all domains released, state RUN
//   fault_o       - retry budget exhausted
//   retry_cnt_o   - consecutive failed bring-ups
//   state_o       - current state code
module clk_rst_seq
    import clk_rst_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned RELEASE_GAP   = 8,
    parameter int unsigned NUM_DOMAINS   = 4,
    parameter int unsigned MAX_RETRIES   = 7
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rst_i,
    input  logic [1:0]             dcm_locked_i,
    input  logic                   pll_locked_i,
    input  logic                   restart_i,
    output logic                   dcm_rst_o,
    output logic                   pll_rst_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_o,
    output logic                   ready_o,
    output logic                   fault_o,
    output logic [3:0]             retry_cnt_o,
    output logic [STATE_W-1:0]     state_o
);

    localparam int unsigned CNT_MAX = max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                                           max2(STABLE_CYCLES, NUM_DOMAINS * RELEASE_GAP));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT     = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'((NUM_DOMAINS - 1) * RELEASE_GAP);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

    logic [1:0] dcm_locked_s;
    logic       pll_locked_s;
    logic       all_dcm;
    logic       all_locked;
    logic       fail;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             retry_q, retry_d;
    logic                   dcm_rst_q, dcm_rst_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;

    lock_sync #(.WIDTH(2)) u_dcm_sync (
        .clk (sys_clk_i),
        .rst (sys_rst_i),
        .d_i (dcm_locked_i),
        .q_o (dcm_locked_s)
    );

    lock_sync #(.WIDTH(1)) u_pll_sync (
        .clk (sys_clk_i),
        .rst (sys_rst_i),
        .d_i (pll_locked_i),
        .q_o (pll_locked_s)
    );

    assign all_dcm    = &dcm_locked_s;
    assign all_locked = all_dcm & pll_locked_s;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fail    = 1'b0;

        case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_DCM;
            end
            ST_WAIT_DCM: begin
                if (all_dcm)               state_d = ST_WAIT_PLL;
                else if (cnt_q == TIMEOUT) fail    = 1'b1;
            end
            ST_WAIT_PLL: begin
                if (!all_dcm)              fail    = 1'b1;
                else if (pll_locked_s)     state_d = ST_STABLE;
                else if (cnt_q == TIMEOUT) fail    = 1'b1;
            end
            ST_STABLE: begin
                if (!all_locked)               fail    = 1'b1;
                else if (cnt_q == STABLE_LAST) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!all_locked)            fail    = 1'b1;
                else if (cnt_q == REL_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!all_locked) fail = 1'b1;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: state_d = ST_RESET;
        endcase

        if (fail) begin
            if (retry_q == RETRY_MAX) begin
                state_d = ST_FAULT;
            end else begin
                retry_d = retry_q + 4'd1;
                state_d = ST_RESET;
            end
        end

        if ((state_d == ST_RUN) && (state_q != ST_RUN)) retry_d = '0;

        // Restart overrides any same-cycle fail, so the retry bump above is discarded.
        if (restart_i) begin
            state_d = ST_RESET;
            retry_d = '0;
        end

        // restart_i from RESET is still a fresh start, so it clears the counter too.
        if ((state_d != state_q) || restart_i) cnt_d = '0;
        else                                   cnt_d = cnt_q + CNT_W'(1);

        // Outputs are decoded from the next state so they switch on the same
        // edge as the state register.
        dcm_rst_d = (state_d == ST_RESET) || (state_d == ST_FAULT);
        pll_rst_d = dcm_rst_d || (state_d == ST_WAIT_DCM);
        ready_d   = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);

        domain_rst_d = '1;
        if (state_d == ST_RELEASE) begin
            domain_rst_d = domain_rst_q;
            for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
                if (cnt_d == CNT_W'(k * RELEASE_GAP)) domain_rst_d[k] = 1'b0;
            end
        end else if (state_d == ST_RUN) begin
            domain_rst_d = '0;
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            retry_q      <= '0;
            dcm_rst_q    <= 1'b1;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            dcm_rst_q    <= dcm_rst_d;
            pll_rst_q    <= pll_rst_d;
            domain_rst_q <= domain_rst_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign dcm_rst_o    = dcm_rst_q;
    assign pll_rst_o    = pll_rst_q;
    assign domain_rst_o = domain_rst_q;
    assign ready_o      = ready_q;
    assign fault_o      = fault_q;
    assign retry_cnt_o  = retry_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Testbench for clk_rst_seq: scenario tasks with inline checks. Expected
// timing is derived from the sequencing rules (RESET length, 2-cycle lock
// synchronizer, stable window, release gap, retry budget) as plain
// arithmetic on cycle offsets.
module tb_clk_rst_seq;

    localparam int unsigned RST_C = 16;
    localparam int unsigned TO    = 255;
    localparam int unsigned STB   = 64;
    localparam int unsigned GAP   = 8;
    localparam int unsigned ND    = 4;
    localparam int unsigned MAXR  = 7;
    localparam int unsigned REL_LEN = (ND - 1) * GAP + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    dcm_locked;
    logic          pll_locked;
    logic          restart;
    logic          dcm_rst;
    logic          pll_rst;
    logic [ND-1:0] domain_rst;
    logic          ready;
    logic          fault;
    logic [3:0]    retry_cnt;
    logic [2:0]    state;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    clk_rst_seq #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (STB),
        .RELEASE_GAP   (GAP),
        .NUM_DOMAINS   (ND),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .sys_clk_i    (clk),
        .sys_rst_i    (rst),
        .dcm_locked_i (dcm_locked),
        .pll_locked_i (pll_locked),
        .restart_i    (restart),
        .dcm_rst_o    (dcm_rst),
        .pll_rst_o    (pll_rst),
        .domain_rst_o (domain_rst),
        .ready_o      (ready),
        .fault_o      (fault),
        .retry_cnt_o  (retry_cnt),
        .state_o      (state)
    );

    // Wait n rising edges, then settle 1ns so registered outputs are stable.
    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] exp_v;
        rst = 1'b1; dcm_locked = 2'b00; pll_locked = 1'b0; restart = 1'b0;
        tick(3);
        exp_v = {3'd0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0};
        total++;
        if ({state, dcm_rst, pll_rst, domain_rst, ready, fault, retry_cnt} !== exp_v) begin
            bad++; $display("FAIL reset_values: got %h want %h", {state, dcm_rst, pll_rst, domain_rst, ready, fault, retry_cnt}, exp_v);
        end
        @(negedge clk); rst = 1'b0;
        tick(RST_C - 1);
        total++;
        if (state !== 3'd0 || dcm_rst !== 1'b1) begin
            bad++; $display("FAIL reset_hold: state=%0d dcm_rst=%b want 0/1", state, dcm_rst);
        end
        tick(1);
        total++;
        if (state !== 3'd1 || dcm_rst !== 1'b0 || pll_rst !== 1'b1) begin
            bad++; $display("FAIL reset_exit: state=%0d dcm=%b pll=%b want 1/0/1", state, dcm_rst, pll_rst);
        end
    endtask

    // Precondition: first cycle of WAIT_DCM, all locks synchronized low.
    task automatic test_bring_up(input int unsigned d1, input int unsigned d2, input bit partial);
        logic [ND-1:0] exp_mask;
        logic [2:0]    exp_state;
        if (partial) begin
            @(negedge clk); dcm_locked = 2'b01;
        end
        repeat (d1) @(negedge clk);
        dcm_locked = 2'b11;
        tick(2);
        total++;
        if (state !== 3'd1) begin
            bad++; $display("FAIL bringup_dcm_sync: state=%0d want 1", state);
        end
        tick(1);
        total++;
        if (state !== 3'd2 || pll_rst !== 1'b0 || dcm_rst !== 1'b0) begin
            bad++; $display("FAIL bringup_wait_pll: state=%0d pll=%b dcm=%b want 2/0/0", state, pll_rst, dcm_rst);
        end
        repeat (d2) @(negedge clk);
        pll_locked = 1'b1;
        tick(2);
        total++;
        if (state !== 3'd2) begin
            bad++; $display("FAIL bringup_pll_sync: state=%0d want 2", state);
        end
        tick(1);
        total++;
        if (state !== 3'd3 || domain_rst !== '1) begin
            bad++; $display("FAIL bringup_stable: state=%0d dom=%b want 3/1111", state, domain_rst);
        end
        tick(STB - 1);
        total++;
        if (state !== 3'd3) begin
            bad++; $display("FAIL bringup_stable_len: state=%0d want 3", state);
        end
        tick(1);
        for (int unsigned t = 0; t <= REL_LEN; t++) begin
            for (int unsigned k = 0; k < ND; k++) exp_mask[k] = (k * GAP > t);
            exp_state = (t >= REL_LEN) ? 3'd5 : 3'd4;
            total++;
            if (domain_rst !== exp_mask || state !== exp_state || ready !== (t >= REL_LEN)) begin
                bad++; $display("FAIL release_t%0d: dom=%b state=%0d ready=%b want %b/%0d/%b", t, domain_rst, state, ready, exp_mask, exp_state, (t >= REL_LEN));
            end
            if (t < REL_LEN) tick(1);
        end
        total++;
        if (retry_cnt !== 4'd0 || fault !== 1'b0) begin
            bad++; $display("FAIL bringup_run_retry: retry=%0d fault=%b want 0/0", retry_cnt, fault);
        end
    endtask

    // Precondition: RUN, all locks high.
    task automatic test_lock_loss();
        int unsigned which;
        which = $urandom_range(0, 2);
        @(negedge clk);
        if (which == 0) pll_locked = 1'b0;
        else if (which == 1) dcm_locked = 2'b10;
        else dcm_locked = 2'b01;
        @(negedge clk);
        dcm_locked = 2'b11; pll_locked = 1'b1;
        tick(1);
        total++;
        if (state !== 3'd5 || ready !== 1'b1) begin
            bad++; $display("FAIL loss_early: state=%0d ready=%b want 5/1 (lock %0d)", state, ready, which);
        end
        tick(1);
        total++;
        if (state !== 3'd0 || domain_rst !== '1 || ready !== 1'b0 || retry_cnt !== 4'd1 || dcm_rst !== 1'b1) begin
            bad++; $display("FAIL loss_react: state=%0d dom=%b ready=%b retry=%0d dcm=%b want 0/1111/0/1/1", state, domain_rst, ready, retry_cnt, dcm_rst);
        end
        // Locks already stable: RESET, one cycle each in WAIT_DCM/WAIT_PLL, STABLE, RELEASE.
        tick(RST_C + 2 + STB + REL_LEN - 1);
        total++;
        if (state !== 3'd4) begin
            bad++; $display("FAIL relock_release: state=%0d want 4", state);
        end
        tick(1);
        total++;
        if (state !== 3'd5 || retry_cnt !== 4'd0 || ready !== 1'b1 || domain_rst !== '0) begin
            bad++; $display("FAIL relock_run: state=%0d retry=%0d ready=%b dom=%b want 5/0/1/0000", state, retry_cnt, ready, domain_rst);
        end
    endtask

    // Precondition: RUN, retry 0.
    task automatic test_dcm_timeout();
        @(negedge clk); dcm_locked = 2'b01;
        tick(3);
        total++;
        if (state !== 3'd0 || retry_cnt !== 4'd1 || domain_rst !== '1) begin
            bad++; $display("FAIL dcmto_loss: state=%0d retry=%0d dom=%b want 0/1/1111", state, retry_cnt, domain_rst);
        end
        tick(RST_C);
        total++;
        if (state !== 3'd1) begin
            bad++; $display("FAIL dcmto_enter: state=%0d want 1", state);
        end
        tick(TO);
        total++;
        if (state !== 3'd1 || pll_rst !== 1'b1) begin
            bad++; $display("FAIL dcmto_wait: state=%0d pll=%b want 1/1", state, pll_rst);
        end
        tick(1);
        total++;
        if (state !== 3'd0 || retry_cnt !== 4'd2 || dcm_rst !== 1'b1) begin
            bad++; $display("FAIL dcmto_expire: state=%0d retry=%0d dcm=%b want 0/2/1", state, retry_cnt, dcm_rst);
        end
        tick(RST_C - 1);
        total++;
        if (dcm_rst !== 1'b1 || state !== 3'd0) begin
            bad++; $display("FAIL dcmto_rst_hold: dcm=%b state=%0d want 1/0", dcm_rst, state);
        end
        tick(1);
        total++;
        if (dcm_rst !== 1'b0 || state !== 3'd1) begin
            bad++; $display("FAIL dcmto_rst_end: dcm=%b state=%0d want 0/1", dcm_rst, state);
        end
    endtask

    task automatic test_retry_exhaustion();
        @(negedge clk); restart = 1'b1; dcm_locked = 2'b11; pll_locked = 1'b0;
        tick(1);
        total++;
        if (state !== 3'd0 || retry_cnt !== 4'd0) begin
            bad++; $display("FAIL exh_restart: state=%0d retry=%0d want 0/0", state, retry_cnt);
        end
        @(negedge clk); restart = 1'b0;
        for (int unsigned i = 1; i <= MAXR + 1; i++) begin
            tick(RST_C + 1 + TO);
            total++;
            if (state !== 3'd2 || pll_rst !== 1'b0) begin
                bad++; $display("FAIL exh_wait_pll_%0d: state=%0d pll=%b want 2/0", i, state, pll_rst);
            end
            tick(1);
            total++;
            if (i <= MAXR) begin
                if (state !== 3'd0 || retry_cnt !== 4'(i)) begin
                    bad++; $display("FAIL exh_fail_%0d: state=%0d retry=%0d want 0/%0d", i, state, retry_cnt, i);
                end
            end else begin
                if (state !== 3'd6 || fault !== 1'b1 || retry_cnt !== 4'(MAXR)) begin
                    bad++; $display("FAIL exh_fault: state=%0d fault=%b retry=%0d want 6/1/%0d", state, fault, retry_cnt, MAXR);
                end
            end
        end
        tick(40);
        total++;
        if (state !== 3'd6 || dcm_rst !== 1'b1 || pll_rst !== 1'b1 || domain_rst !== '1 || ready !== 1'b0 || fault !== 1'b1) begin
            bad++; $display("FAIL exh_hold: state=%0d dcm=%b pll=%b dom=%b ready=%b fault=%b want 6/1/1/1111/0/1", state, dcm_rst, pll_rst, domain_rst, ready, fault);
        end
        @(negedge clk); restart = 1'b1;
        tick(1);
        total++;
        if (state !== 3'd0 || retry_cnt !== 4'd0 || fault !== 1'b0) begin
            bad++; $display("FAIL exh_release: state=%0d retry=%0d fault=%b want 0/0/0", state, retry_cnt, fault);
        end
    endtask

    // Precondition: restart_i high, just sampled at an edge entering RESET.
    task automatic test_restart_priority();
        @(negedge clk); restart = 1'b0; pll_locked = 1'b1;
        tick(RST_C + 2);
        total++;
        if (state !== 3'd3) begin
            bad++; $display("FAIL prio_stable1: state=%0d want 3", state);
        end
        @(negedge clk); dcm_locked = 2'b10;
        @(negedge clk); dcm_locked = 2'b11;
        tick(1);
        total++;
        if (state !== 3'd3) begin
            bad++; $display("FAIL prio_glitch_early: state=%0d want 3", state);
        end
        tick(1);
        total++;
        if (state !== 3'd0 || retry_cnt !== 4'd1) begin
            bad++; $display("FAIL prio_glitch_fail: state=%0d retry=%0d want 0/1", state, retry_cnt);
        end
        tick(RST_C + 2);
        total++;
        if (state !== 3'd3) begin
            bad++; $display("FAIL prio_stable2: state=%0d want 3", state);
        end
        @(negedge clk); pll_locked = 1'b0;
        @(negedge clk);
        @(negedge clk); restart = 1'b1;
        tick(1);
        total++;
        if (state !== 3'd0 || retry_cnt !== 4'd0) begin
            bad++; $display("FAIL prio_restart: state=%0d retry=%0d want 0/0", state, retry_cnt);
        end
        @(negedge clk); restart = 1'b0;
        tick(1);
        total++;
        if (state !== 3'd0 || retry_cnt !== 4'd0) begin
            bad++; $display("FAIL prio_after: state=%0d retry=%0d want 0/0", state, retry_cnt);
        end
    endtask

    // Precondition: one cycle after RESET entry (Q+1), PLL low, DCMs locked.
    task automatic test_async_reset_release();
        logic [15:0] exp_v;
        @(negedge clk); pll_locked = 1'b1;
        // RELEASE starts at Q+RST_C+2+STB; bit 1 drops GAP cycles later.
        tick(RST_C + 2 + STB + GAP - 2);
        total++;
        if (state !== 3'd4 || domain_rst !== 4'b1110) begin
            bad++; $display("FAIL arst_pre: state=%0d dom=%b want 4/1110", state, domain_rst);
        end
        tick(1);
        total++;
        if (state !== 3'd4 || domain_rst !== 4'b1100) begin
            bad++; $display("FAIL arst_two_released: state=%0d dom=%b want 4/1100", state, domain_rst);
        end
        #2 rst = 1'b1;
        #1;
        exp_v = {3'd0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0};
        total++;
        if ({state, dcm_rst, pll_rst, domain_rst, ready, fault, retry_cnt} !== exp_v) begin
            bad++; $display("FAIL arst_immediate: got %h want %h", {state, dcm_rst, pll_rst, domain_rst, ready, fault, retry_cnt}, exp_v);
        end
        tick(2);
    endtask

    task automatic test_back_to_back();
        for (int unsigned j = 0; j < 3; j++) begin
            @(negedge clk);
            rst = 1'b0; restart = 1'b1; dcm_locked = 2'b00; pll_locked = 1'b0;
            tick(1);
            @(negedge clk); restart = 1'b0;
            tick(RST_C - 1);
            total++;
            if (state !== 3'd0) begin
                bad++; $display("FAIL b2b_reset_%0d: state=%0d want 0", j, state);
            end
            tick(1);
            test_bring_up($urandom_range(1, 100), $urandom_range(1, 60), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bring_up($urandom_range(1, 100), $urandom_range(1, 60), 1'b0);
        test_lock_loss();
        test_dcm_timeout();
        test_retry_exhaustion();
        test_restart_priority();
        test_async_reset_release();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
